ifetch_unit: RTL and testbench

- Instruction fetch initiator that drives the read side of the instruction memory (IM) port.
- Holds the program counter, issues one word read per cycle, and captures the returned word with its PC into a small instruction queue.
- Presents queue entries to decode over a valid/ready handshake.
- Supports pipeline redirect (branch/jump) with a queue flush, plus a global fetch enable.

---
 rtl/ifetch_unit.sv | 94 +++++++++
 tb/tb_ifetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch initiator: owns the PC, reads one IM word per cycle and
// queues {word, pc} pairs for decode, with redirect/flush and fetch enable.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        IM_enable,
  output logic        IM_write,
  output logic [31:0] IM_in,
  output logic [15:0] IM_address,
  input  logic [31:0] IM_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [3:0]  q_count
);

  // Handshake: decode takes the head on any cycle where out_valid && out_ready
  // are both high at the rising edge; out_valid depends only on registered state.

  localparam int          PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [3:0]  QD = 4'(QDEPTH);

  logic [31:0]   pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [3:0]    count;
  logic [31:0]   inst_q [QDEPTH];
  logic [31:0]   pc_q   [QDEPTH];
  logic [31:0]   hold_inst;
  logic [31:0]   hold_pc;
  logic          pop;
  logic          issue;

  assign out_valid  = (count != 4'd0);
  assign pop        = out_valid & out_ready;
  // A pop frees a slot this same cycle, so a full queue still sustains 1/cycle.
  assign issue      = ~rst & fetch_en & ~redirect_valid & ((count < QD) | pop);

  assign IM_enable  = ~issue;
  assign IM_write   = 1'b1;
  assign IM_in      = 32'd0;
  assign IM_address = pc[17:2];
  assign q_count    = count;

  // When empty, the outputs keep showing the last instruction that was taken.
  assign out_inst   = out_valid ? inst_q[rd_ptr] : hold_inst;
  assign out_pc     = out_valid ? pc_q[rd_ptr]   : hold_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC & ~32'h3;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= 4'd0;
      hold_inst <= 32'd0;
      hold_pc   <= 32'd0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc & ~32'h3;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 4'd0;
    end else begin
      if (issue) begin
        pc     <= pc + 32'd4;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        hold_inst <= inst_q[rd_ptr];
        hold_pc   <= pc_q[rd_ptr];
      end
      case ({issue, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      inst_q[wr_ptr] <= IM_out;
      pc_q[wr_ptr]   <= pc;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus randomized traffic checked
// against a queue-level reference of the fetch stream.
module tb_ifetch_unit;

  localparam int          QDEPTH   = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, fetch_en, redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic        IM_enable, IM_write, out_valid;
  logic [31:0] IM_in, IM_out, out_inst, out_pc;
  logic [15:0] IM_address;
  logic [3:0]  q_count;

  logic [31:0] mem [0:65535];
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  int          n_checks = 0;
  int          n_pass   = 0;

  ifetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .IM_enable(IM_enable), .IM_write(IM_write),
    .IM_in(IM_in), .IM_address(IM_address), .IM_out(IM_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .q_count(q_count)
  );

  // clock / reset block
  always #5 clk = ~clk;
  assign IM_out = mem[IM_address];

  // driver: applied just after a falling edge, outputs settle by #1
  task automatic drive(input logic rs, input logic fe, input logic rv,
                       input logic [31:0] rpc, input logic rdy);
    rst = rs; fetch_en = fe; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    #1;
  endtask

  function automatic logic m_issue();
    return !rst && fetch_en && !redirect_valid &&
           (exp_q.size() < QDEPTH || (exp_q.size() != 0 && out_ready));
  endfunction

  // advances the reference by one cycle, then moves to the next falling edge
  task automatic tick();
    logic iss;
    iss = m_issue();
    if (rst) begin
      m_pc = {RESET_PC[31:2], 2'b00};
      exp_q.delete();
    end else if (redirect_valid) begin
      m_pc = {redirect_pc[31:2], 2'b00};
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (iss) begin
        exp_q.push_back({mem[m_pc[17:2]], m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 32'h0, 1);
    n_checks++; if (IM_enable !== 1'b1) $display("FAIL rst_im_enable got %0b want 1", IM_enable); else n_pass++;
    tick(); tick();
    drive(1, 1, 0, 32'h0, 1);
    n_checks++; if (q_count !== 4'd0) $display("FAIL rst_q_count got %0d want 0", q_count); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (out_inst !== 32'd0) $display("FAIL rst_out_inst got %h want 0", out_inst); else n_pass++;
    n_checks++; if (out_pc !== 32'd0) $display("FAIL rst_out_pc got %h want 0", out_pc); else n_pass++;
    n_checks++; if (IM_enable !== 1'b1) $display("FAIL rst_im_enable2 got %0b want 1", IM_enable); else n_pass++;
  endtask

  task automatic test_sequential();
    logic [31:0] tab [4];
    tab[0] = 32'h11; tab[1] = 32'h22; tab[2] = 32'h33; tab[3] = 32'h44;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 32'h0, 1);
      n_checks++; if (IM_enable !== 1'b0) $display("FAIL seq_im_enable[%0d] got %0b want 0", i, IM_enable); else n_pass++;
      n_checks++; if (IM_address !== 16'(i)) $display("FAIL seq_addr[%0d] got %h want %h", i, IM_address, 16'(i)); else n_pass++;
      if (i == 0) begin
        n_checks++; if (out_valid !== 1'b0) $display("FAIL seq_first_valid got %0b want 0", out_valid); else n_pass++;
      end else begin
        n_checks++; if (out_valid !== 1'b1) $display("FAIL seq_valid[%0d] got %0b want 1", i, out_valid); else n_pass++;
        n_checks++; if (out_inst !== tab[i-1]) $display("FAIL seq_inst[%0d] got %h want %h", i, out_inst, tab[i-1]); else n_pass++;
        n_checks++; if (out_pc !== 32'((i-1)*4)) $display("FAIL seq_pc[%0d] got %h want %h", i, out_pc, 32'((i-1)*4)); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    drive(1, 0, 0, 32'h0, 0); tick();
    for (int i = 0; i < 4; i++) begin drive(0, 1, 0, 32'h0, 0); tick(); end
    drive(0, 1, 0, 32'h0, 0);
    n_checks++; if (q_count !== 4'd2) $display("FAIL bp_q_count got %0d want 2", q_count); else n_pass++;
    n_checks++; if (IM_enable !== 1'b1) $display("FAIL bp_im_enable got %0b want 1", IM_enable); else n_pass++;
    n_checks++; if (IM_address !== 16'd2) $display("FAIL bp_pc_addr got %h want 2", IM_address); else n_pass++;
    n_checks++; if (out_pc !== 32'h0) $display("FAIL bp_head_pc got %h want 0", out_pc); else n_pass++;
    drive(0, 1, 0, 32'h0, 1);
    n_checks++; if (IM_enable !== 1'b0) $display("FAIL bp_ready_comb got %0b want 0", IM_enable); else n_pass++;
    for (int i = 0; i < 30; i++) begin
      drive(0, 1, 0, 32'h0, 1'($urandom_range(0, 1)));
      n_checks++; if (IM_enable !== !m_issue()) $display("FAIL bp_rand_en[%0d] got %0b want %0b", i, IM_enable, !m_issue()); else n_pass++;
      n_checks++; if (q_count !== 4'(exp_q.size())) $display("FAIL bp_rand_cnt[%0d] got %0d want %0d", i, q_count, exp_q.size()); else n_pass++;
      if (exp_q.size() != 0) begin
        n_checks++; if ({out_inst, out_pc} !== exp_q[0]) $display("FAIL bp_rand_head[%0d] got %h want %h", i, {out_inst, out_pc}, exp_q[0]); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 3; i++) begin drive(0, 1, 0, 32'h0, 0); tick(); end
    drive(0, 1, 1, 32'h0000_0103, 1);
    n_checks++; if (q_count !== 4'd2) $display("FAIL rd_pre_count got %0d want 2", q_count); else n_pass++;
    n_checks++; if (IM_enable !== 1'b1) $display("FAIL rd_no_issue got %0b want 1", IM_enable); else n_pass++;
    tick();
    drive(0, 1, 0, 32'h0, 1);
    n_checks++; if (q_count !== 4'd0) $display("FAIL rd_flush_count got %0d want 0", q_count); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rd_flush_valid got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (IM_address !== 16'h0040) $display("FAIL rd_addr got %h want 0040", IM_address); else n_pass++;
    n_checks++; if (IM_enable !== 1'b0) $display("FAIL rd_issue got %0b want 0", IM_enable); else n_pass++;
    tick();
    drive(0, 1, 0, 32'h0, 1);
    n_checks++; if (out_pc !== 32'h100) $display("FAIL rd_out_pc got %h want 100", out_pc); else n_pass++;
    n_checks++; if (out_inst !== mem[16'h0040]) $display("FAIL rd_out_inst got %h want %h", out_inst, mem[16'h0040]); else n_pass++;
    tick();
  endtask

  task automatic test_wrap();
    drive(0, 1, 1, 32'hFFFF_FFFC, 1); tick();
    drive(0, 1, 0, 32'h0, 1);
    n_checks++; if (IM_address !== 16'hFFFF) $display("FAIL wrap_addr0 got %h want FFFF", IM_address); else n_pass++;
    tick();
    drive(0, 1, 0, 32'h0, 1);
    n_checks++; if (IM_address !== 16'h0000) $display("FAIL wrap_addr1 got %h want 0000", IM_address); else n_pass++;
    n_checks++; if (out_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc0 got %h want FFFFFFFC", out_pc); else n_pass++;
    tick();
    drive(0, 1, 0, 32'h0, 1);
    n_checks++; if (out_pc !== 32'h0) $display("FAIL wrap_pc1 got %h want 00000000", out_pc); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin drive(0, 1, 0, 32'h0, 0); tick(); end
    drive(1, 1, 1, 32'h0000_0500, 1);
    n_checks++; if (q_count !== 4'd2) $display("FAIL rm_pre_count got %0d want 2", q_count); else n_pass++;
    n_checks++; if (IM_enable !== 1'b1) $display("FAIL rm_im_enable got %0b want 1", IM_enable); else n_pass++;
    tick();
    drive(0, 1, 0, 32'h0, 1);
    n_checks++; if (q_count !== 4'd0) $display("FAIL rm_count got %0d want 0", q_count); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rm_valid got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (IM_address !== RESET_PC[17:2]) $display("FAIL rm_pc got %h want %h", IM_address, RESET_PC[17:2]); else n_pass++;
    tick();
  endtask

  task automatic test_fetch_en_toggle();
    logic [7:0]  fe_pat;
    logic [31:0] last_pc;
    logic        have_last;
    logic [15:0] frozen;
    fe_pat = 8'b1101_1101;
    have_last = 1'b0;
    last_pc = 32'h0;
    for (int i = 0; i < 8; i++) begin
      drive(0, fe_pat[i], 0, 32'h0, 1);
      if (i > 0 && !fe_pat[i-1]) begin
        n_checks++; if (IM_address !== frozen) $display("FAIL fe_frozen[%0d] got %h want %h", i, IM_address, frozen); else n_pass++;
      end
      if (!fe_pat[i]) begin
        frozen = IM_address;
        n_checks++; if (IM_enable !== 1'b1) $display("FAIL fe_off_issue[%0d] got %0b want 1", i, IM_enable); else n_pass++;
      end
      if (out_valid) begin
        if (have_last) begin
          n_checks++; if (out_pc !== last_pc + 32'd4) $display("FAIL fe_seq[%0d] got %h want %h", i, out_pc, last_pc + 32'd4); else n_pass++;
        end
        last_pc = out_pc;
        have_last = 1'b1;
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0), $urandom, 1'($urandom_range(0, 2) != 0));
      n_checks++; if (IM_enable !== !m_issue()) $display("FAIL rnd_en[%0d] got %0b want %0b", i, IM_enable, !m_issue()); else n_pass++;
      if (m_issue()) begin
        n_checks++; if (IM_address !== m_pc[17:2]) $display("FAIL rnd_addr[%0d] got %h want %h", i, IM_address, m_pc[17:2]); else n_pass++;
      end
      n_checks++; if (q_count !== 4'(exp_q.size())) $display("FAIL rnd_cnt[%0d] got %0d want %0d", i, q_count, exp_q.size()); else n_pass++;
      n_checks++; if (out_valid !== (exp_q.size() != 0)) $display("FAIL rnd_valid[%0d] got %0b want %0b", i, out_valid, exp_q.size() != 0); else n_pass++;
      if (exp_q.size() != 0) begin
        n_checks++; if ({out_inst, out_pc} !== exp_q[0]) $display("FAIL rnd_head[%0d] got %h want %h", i, {out_inst, out_pc}, exp_q[0]); else n_pass++;
      end
      n_checks++; if (IM_write !== 1'b1 || IM_in !== 32'd0) $display("FAIL rnd_tieoff[%0d] got %0b/%h want 1/0", i, IM_write, IM_in); else n_pass++;
      tick();
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = $urandom;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    m_pc = 32'h0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_fetch_en_toggle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
